// File: rtl/axi_lite_arbiter_2to1.sv
// Two-requester AXI-Lite arbiter in front of one slave; independent write and read arbiters.
// Define AXI_LITE_ARB_FIXED_PRIO_EN for fixed in0 priority instead of round-robin.
module axi_lite_arbiter_2to1 #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  localparam int STRB_WIDTH = (AXI_DATA_WIDTH + 7) / 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AXI_ADDR_WIDTH-1:0] in0_axi_awaddr,
  input  logic                      in0_axi_awvalid,
  output logic                      in0_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] in0_axi_wdata,
  input  logic [STRB_WIDTH-1:0]     in0_axi_wstrb,
  input  logic                      in0_axi_wvalid,
  output logic                      in0_axi_wready,
  output logic [1:0]                in0_axi_bresp,
  output logic                      in0_axi_bvalid,
  input  logic                      in0_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] in0_axi_araddr,
  input  logic                      in0_axi_arvalid,
  output logic                      in0_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] in0_axi_rdata,
  output logic [1:0]                in0_axi_rresp,
  output logic                      in0_axi_rvalid,
  input  logic                      in0_axi_rready,
  input  logic [AXI_ADDR_WIDTH-1:0] in1_axi_awaddr,
  input  logic                      in1_axi_awvalid,
  output logic                      in1_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0] in1_axi_wdata,
  input  logic [STRB_WIDTH-1:0]     in1_axi_wstrb,
  input  logic                      in1_axi_wvalid,
  output logic                      in1_axi_wready,
  output logic [1:0]                in1_axi_bresp,
  output logic                      in1_axi_bvalid,
  input  logic                      in1_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] in1_axi_araddr,
  input  logic                      in1_axi_arvalid,
  output logic                      in1_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0] in1_axi_rdata,
  output logic [1:0]                in1_axi_rresp,
  output logic                      in1_axi_rvalid,
  input  logic                      in1_axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0] out_axi_awaddr,
  output logic                      out_axi_awvalid,
  input  logic                      out_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0] out_axi_wdata,
  output logic [STRB_WIDTH-1:0]     out_axi_wstrb,
  output logic                      out_axi_wvalid,
  input  logic                      out_axi_wready,
  input  logic [1:0]                out_axi_bresp,
  input  logic                      out_axi_bvalid,
  output logic                      out_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0] out_axi_araddr,
  output logic                      out_axi_arvalid,
  input  logic                      out_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] out_axi_rdata,
  input  logic [1:0]                out_axi_rresp,
  input  logic                      out_axi_rvalid,
  output logic                      out_axi_rready
);

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} r_state_t;

  w_state_t w_state, w_state_next;
  r_state_t r_state, r_state_next;
  logic     w_gnt, w_gnt_next, aw_done, w_done;
  logic     r_gnt, r_gnt_next;
  logic     g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;
  logic     aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic     w_pick, r_pick;

  assign g_awvalid = w_gnt ? in1_axi_awvalid : in0_axi_awvalid;
  assign g_wvalid  = w_gnt ? in1_axi_wvalid  : in0_axi_wvalid;
  assign g_bready  = w_gnt ? in1_axi_bready  : in0_axi_bready;
  assign g_arvalid = r_gnt ? in1_axi_arvalid : in0_axi_arvalid;
  assign g_rready  = r_gnt ? in1_axi_rready  : in0_axi_rready;

  assign aw_hs = (w_state == W_XFER) && g_awvalid && !aw_done && out_axi_awready;
  assign w_hs  = (w_state == W_XFER) && g_wvalid && !w_done && out_axi_wready;
  assign b_hs  = (w_state == W_RESP) && g_bready && out_axi_bvalid;
  assign ar_hs = (r_state == R_ADDR) && g_arvalid && out_axi_arready;
  assign r_hs  = (r_state == R_RESP) && g_rready && out_axi_rvalid;

`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
  assign w_pick = !in0_axi_awvalid;
  assign r_pick = !in0_axi_arvalid;
`else
  // prio holds the requester that wins the next tie; it moves only when a transaction completes
  logic w_prio, r_prio;
  assign w_pick = (in0_axi_awvalid && in1_axi_awvalid) ? w_prio : in1_axi_awvalid;
  assign r_pick = (in0_axi_arvalid && in1_axi_arvalid) ? r_prio : in1_axi_arvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_prio <= 1'b0;
      r_prio <= 1'b0;
    end else begin
      if (b_hs) w_prio <= !w_gnt;
      if (r_hs) r_prio <= !r_gnt;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_gnt   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_state_next;
      w_gnt   <= w_gnt_next;
      aw_done <= b_hs ? 1'b0 : (aw_done || aw_hs);
      w_done  <= b_hs ? 1'b0 : (w_done || w_hs);
    end
  end

  always_comb begin
    w_state_next = w_state;
    w_gnt_next   = w_gnt;
    case (w_state)
      W_IDLE: if (in0_axi_awvalid || in1_axi_awvalid) begin
        w_state_next = W_XFER;
        w_gnt_next   = w_pick;
      end
      W_XFER: if ((aw_done || aw_hs) && (w_done || w_hs)) w_state_next = W_RESP;
      W_RESP: if (b_hs) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    logic xfer, resp;
    xfer = (w_state == W_XFER);
    resp = (w_state == W_RESP);
    out_axi_awaddr  = w_gnt ? in1_axi_awaddr : in0_axi_awaddr;
    out_axi_wdata   = w_gnt ? in1_axi_wdata  : in0_axi_wdata;
    out_axi_wstrb   = w_gnt ? in1_axi_wstrb  : in0_axi_wstrb;
    out_axi_awvalid = xfer && g_awvalid && !aw_done;
    out_axi_wvalid  = xfer && g_wvalid && !w_done;
    out_axi_bready  = resp && g_bready;
    in0_axi_awready = xfer && !w_gnt && !aw_done && out_axi_awready;
    in1_axi_awready = xfer &&  w_gnt && !aw_done && out_axi_awready;
    in0_axi_wready  = xfer && !w_gnt && !w_done && out_axi_wready;
    in1_axi_wready  = xfer &&  w_gnt && !w_done && out_axi_wready;
    in0_axi_bvalid  = resp && !w_gnt && out_axi_bvalid;
    in1_axi_bvalid  = resp &&  w_gnt && out_axi_bvalid;
    in0_axi_bresp   = (resp && !w_gnt) ? out_axi_bresp : '0;
    in1_axi_bresp   = (resp &&  w_gnt) ? out_axi_bresp : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_gnt   <= 1'b0;
    end else begin
      r_state <= r_state_next;
      r_gnt   <= r_gnt_next;
    end
  end

  always_comb begin
    r_state_next = r_state;
    r_gnt_next   = r_gnt;
    case (r_state)
      R_IDLE: if (in0_axi_arvalid || in1_axi_arvalid) begin
        r_state_next = R_ADDR;
        r_gnt_next   = r_pick;
      end
      R_ADDR: if (ar_hs) r_state_next = R_RESP;
      R_RESP: if (r_hs) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  always_comb begin
    logic addr, resp;
    addr = (r_state == R_ADDR);
    resp = (r_state == R_RESP);
    out_axi_araddr  = r_gnt ? in1_axi_araddr : in0_axi_araddr;
    out_axi_arvalid = addr && g_arvalid;
    out_axi_rready  = resp && g_rready;
    in0_axi_arready = addr && !r_gnt && out_axi_arready;
    in1_axi_arready = addr &&  r_gnt && out_axi_arready;
    in0_axi_rvalid  = resp && !r_gnt && out_axi_rvalid;
    in1_axi_rvalid  = resp &&  r_gnt && out_axi_rvalid;
    in0_axi_rdata   = (resp && !r_gnt) ? out_axi_rdata : '0;
    in1_axi_rdata   = (resp &&  r_gnt) ? out_axi_rdata : '0;
    in0_axi_rresp   = (resp && !r_gnt) ? out_axi_rresp : '0;
    in1_axi_rresp   = (resp &&  r_gnt) ? out_axi_rresp : '0;
  end

endmodule

// File: tb/tb_axi_lite_arbiter_2to1.sv
// Bench for axi_lite_arbiter_2to1: two requester tasks, a randomly stalling slave with memory,
// and a reference model of memory contents and grant order.
module tb_axi_lite_arbiter_2to1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [19:0] in0_axi_awaddr = '0, in1_axi_awaddr = '0, in0_axi_araddr = '0, in1_axi_araddr = '0;
  logic        in0_axi_awvalid = 0, in1_axi_awvalid = 0, in0_axi_wvalid = 0, in1_axi_wvalid = 0;
  logic [15:0] in0_axi_wdata = '0, in1_axi_wdata = '0;
  logic [1:0]  in0_axi_wstrb = '1, in1_axi_wstrb = '1;
  logic        in0_axi_bready = 0, in1_axi_bready = 0, in0_axi_arvalid = 0, in1_axi_arvalid = 0;
  logic        in0_axi_rready = 0, in1_axi_rready = 0;
  logic        in0_axi_awready, in1_axi_awready, in0_axi_wready, in1_axi_wready;
  logic [1:0]  in0_axi_bresp, in1_axi_bresp, in0_axi_rresp, in1_axi_rresp;
  logic        in0_axi_bvalid, in1_axi_bvalid, in0_axi_arready, in1_axi_arready;
  logic [15:0] in0_axi_rdata, in1_axi_rdata;
  logic        in0_axi_rvalid, in1_axi_rvalid;
  logic [19:0] out_axi_awaddr, out_axi_araddr;
  logic        out_axi_awvalid, out_axi_wvalid, out_axi_bready, out_axi_arvalid, out_axi_rready;
  logic [15:0] out_axi_wdata;
  logic [1:0]  out_axi_wstrb;
  logic        out_axi_awready = 0, out_axi_wready = 0, out_axi_bvalid = 0;
  logic        out_axi_arready = 0, out_axi_rvalid = 0;
  logic [1:0]  out_axi_bresp = '0, out_axi_rresp = '0;
  logic [15:0] out_axi_rdata = '0;

  axi_lite_arbiter_2to1 #(.AXI_ADDR_WIDTH(20), .AXI_DATA_WIDTH(16)) dut (
    .clk(clk), .reset(rst),
    .in0_axi_awaddr(in0_axi_awaddr), .in0_axi_awvalid(in0_axi_awvalid), .in0_axi_awready(in0_axi_awready),
    .in0_axi_wdata(in0_axi_wdata), .in0_axi_wstrb(in0_axi_wstrb), .in0_axi_wvalid(in0_axi_wvalid),
    .in0_axi_wready(in0_axi_wready), .in0_axi_bresp(in0_axi_bresp), .in0_axi_bvalid(in0_axi_bvalid),
    .in0_axi_bready(in0_axi_bready), .in0_axi_araddr(in0_axi_araddr), .in0_axi_arvalid(in0_axi_arvalid),
    .in0_axi_arready(in0_axi_arready), .in0_axi_rdata(in0_axi_rdata), .in0_axi_rresp(in0_axi_rresp),
    .in0_axi_rvalid(in0_axi_rvalid), .in0_axi_rready(in0_axi_rready),
    .in1_axi_awaddr(in1_axi_awaddr), .in1_axi_awvalid(in1_axi_awvalid), .in1_axi_awready(in1_axi_awready),
    .in1_axi_wdata(in1_axi_wdata), .in1_axi_wstrb(in1_axi_wstrb), .in1_axi_wvalid(in1_axi_wvalid),
    .in1_axi_wready(in1_axi_wready), .in1_axi_bresp(in1_axi_bresp), .in1_axi_bvalid(in1_axi_bvalid),
    .in1_axi_bready(in1_axi_bready), .in1_axi_araddr(in1_axi_araddr), .in1_axi_arvalid(in1_axi_arvalid),
    .in1_axi_arready(in1_axi_arready), .in1_axi_rdata(in1_axi_rdata), .in1_axi_rresp(in1_axi_rresp),
    .in1_axi_rvalid(in1_axi_rvalid), .in1_axi_rready(in1_axi_rready),
    .out_axi_awaddr(out_axi_awaddr), .out_axi_awvalid(out_axi_awvalid), .out_axi_awready(out_axi_awready),
    .out_axi_wdata(out_axi_wdata), .out_axi_wstrb(out_axi_wstrb), .out_axi_wvalid(out_axi_wvalid),
    .out_axi_wready(out_axi_wready), .out_axi_bresp(out_axi_bresp), .out_axi_bvalid(out_axi_bvalid),
    .out_axi_bready(out_axi_bready), .out_axi_araddr(out_axi_araddr), .out_axi_arvalid(out_axi_arvalid),
    .out_axi_arready(out_axi_arready), .out_axi_rdata(out_axi_rdata), .out_axi_rresp(out_axi_rresp),
    .out_axi_rvalid(out_axi_rvalid), .out_axi_rready(out_axi_rready)
  );

  int n_cmp = 0, n_mis = 0;
  int wr_q[$], rd_q[$], exp_q[$];
  int model_last_w = 1, model_last_r = 1;
  int wr_cnt[2] = '{0, 0};
  int s_wr_cnt = 0, excl_viol = 0, mon1 = 0, mon4 = 0;
  bit t1 = 0, t4 = 0;
  logic [15:0] ref_mem [int];
  logic [15:0] slave_mem [int];
  logic [19:0] a0_q[$], a1_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected grant sequence when both requesters keep re-requesting until their counts run out
  task automatic rr_model(input int c0, input int c1, inout int last);
    int w;
    exp_q.delete();
    while (c0 > 0 || c1 > 0) begin
      if (c0 > 0 && c1 > 0) begin
`ifdef AXI_LITE_ARB_FIXED_PRIO_EN
        w = 0;
`else
        w = (last == 0) ? 1 : 0;
`endif
      end else w = (c0 > 0) ? 0 : 1;
      exp_q.push_back(w);
      if (w == 0) c0--; else c1--;
      last = w;
    end
  endtask

  function automatic logic get_awready(input int n); return n ? in1_axi_awready : in0_axi_awready; endfunction
  function automatic logic get_wready(input int n);  return n ? in1_axi_wready  : in0_axi_wready;  endfunction
  function automatic logic get_bvalid(input int n);  return n ? in1_axi_bvalid  : in0_axi_bvalid;  endfunction
  function automatic logic [1:0] get_bresp(input int n); return n ? in1_axi_bresp : in0_axi_bresp; endfunction
  function automatic logic get_arready(input int n); return n ? in1_axi_arready : in0_axi_arready; endfunction
  function automatic logic get_rvalid(input int n);  return n ? in1_axi_rvalid  : in0_axi_rvalid;  endfunction
  function automatic logic [15:0] get_rdata(input int n); return n ? in1_axi_rdata : in0_axi_rdata; endfunction
  function automatic logic [1:0] get_rresp(input int n); return n ? in1_axi_rresp : in0_axi_rresp; endfunction

  task automatic drive_aw(input int n, input logic v, input logic [19:0] a);
    if (n == 0) begin in0_axi_awvalid = v; in0_axi_awaddr = a; end
    else begin in1_axi_awvalid = v; in1_axi_awaddr = a; end
  endtask
  task automatic drive_w(input int n, input logic v, input logic [15:0] d);
    if (n == 0) begin in0_axi_wvalid = v; in0_axi_wdata = d; end
    else begin in1_axi_wvalid = v; in1_axi_wdata = d; end
  endtask
  task automatic drive_b(input int n, input logic v);
    if (n == 0) in0_axi_bready = v; else in1_axi_bready = v;
  endtask
  task automatic drive_ar(input int n, input logic v, input logic [19:0] a);
    if (n == 0) begin in0_axi_arvalid = v; in0_axi_araddr = a; end
    else begin in1_axi_arvalid = v; in1_axi_araddr = a; end
  endtask
  task automatic drive_r(input int n, input logic v);
    if (n == 0) in0_axi_rready = v; else in1_axi_rready = v;
  endtask

  // Called at a negedge; returns at the negedge after the b handshake
  task automatic do_write(input int n, input logic [19:0] a, input logic [15:0] d);
    bit aw_p = 1, w_p = 1, h_aw, h_w, h_b, ok = 0;
    logic [1:0] resp = '0;
    drive_aw(n, 1, a); drive_w(n, 1, d); drive_b(n, 1);
    for (int c = 0; c < 400 && !ok; c++) begin
      #1;
      h_aw = aw_p && get_awready(n);
      h_w  = w_p && get_wready(n);
      h_b  = get_bvalid(n);
      if (h_b) resp = get_bresp(n);
      if (h_aw) wr_q.push_back(n);
      @(negedge clk);
      if (h_aw) begin drive_aw(n, 0, a); aw_p = 0; end
      if (h_w) begin drive_w(n, 0, d); w_p = 0; end
      if (h_b) begin drive_b(n, 0); ok = 1; end
    end
    check("wr_done", 32'(ok), 1);
    if (ok) begin
      check("wr_bresp", 32'(resp), 32'(a[1:0]));
      ref_mem[int'(a)] = d;
      wr_cnt[n]++;
    end else begin
      drive_aw(n, 0, a); drive_w(n, 0, d); drive_b(n, 0);
    end
  endtask

  task automatic do_read(input int n, input logic [19:0] a, output logic [15:0] d, output bit ok);
    bit ar_p = 1, h_ar, h_r;
    logic [1:0] resp = '0;
    ok = 0; d = '0;
    drive_ar(n, 1, a); drive_r(n, 1);
    for (int c = 0; c < 400 && !ok; c++) begin
      #1;
      h_ar = ar_p && get_arready(n);
      h_r  = get_rvalid(n);
      if (h_r) begin d = get_rdata(n); resp = get_rresp(n); end
      if (h_ar) rd_q.push_back(n);
      @(negedge clk);
      if (h_ar) begin drive_ar(n, 0, a); ar_p = 0; end
      if (h_r) begin drive_r(n, 0); ok = 1; end
    end
    check("rd_done", 32'(ok), 1);
    if (ok) check("rd_rresp", 32'(resp), 32'(a[1:0]));
    else begin drive_ar(n, 0, a); drive_r(n, 0); end
  endtask

  task automatic apply_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_last_w = 1;
    model_last_r = 1;
  endtask

  // Slave write channel: random ready stalls, response code = addr[1:0]
  initial begin
    logic [19:0] sa;
    logic [15:0] sd;
    bit got_a, got_w, h;
    forever begin
      got_a = 0; got_w = 0; sa = '0; sd = '0;
      while (!(got_a && got_w)) begin
        @(negedge clk);
        if (rst) begin got_a = 0; got_w = 0; out_axi_awready = 0; out_axi_wready = 0; continue; end
        out_axi_awready = got_a ? 1'b0 : 1'($urandom_range(0, 1));
        out_axi_wready  = got_w ? 1'b0 : 1'($urandom_range(0, 1));
        #1;
        if (!got_a && out_axi_awvalid && out_axi_awready) begin got_a = 1; sa = out_axi_awaddr; end
        if (!got_w && out_axi_wvalid && out_axi_wready) begin got_w = 1; sd = out_axi_wdata; end
      end
      @(negedge clk);
      out_axi_awready = 0; out_axi_wready = 0;
      repeat ($urandom_range(0, 2)) if (!rst) @(negedge clk);
      if (!rst) begin
        slave_mem[int'(sa)] = sd;
        s_wr_cnt++;
        out_axi_bresp = sa[1:0];
        out_axi_bvalid = 1;
        h = 0;
        while (!h && !rst) begin #1; h = out_axi_bready; @(negedge clk); end
        out_axi_bvalid = 0; out_axi_bresp = '0;
      end
    end
  end

  // Slave read channel
  initial begin
    logic [19:0] sa;
    bit got, h;
    forever begin
      got = 0; sa = '0;
      while (!got) begin
        @(negedge clk);
        if (rst) begin out_axi_arready = 0; continue; end
        out_axi_arready = 1'($urandom_range(0, 1));
        #1;
        if (out_axi_arvalid && out_axi_arready) begin got = 1; sa = out_axi_araddr; end
      end
      @(negedge clk);
      out_axi_arready = 0;
      repeat ($urandom_range(0, 2)) if (!rst) @(negedge clk);
      if (!rst) begin
        out_axi_rdata = slave_mem.exists(int'(sa)) ? slave_mem[int'(sa)] : 16'h0000;
        out_axi_rresp = sa[1:0];
        out_axi_rvalid = 1;
        h = 0;
        while (!h && !rst) begin #1; h = out_axi_rready; @(negedge clk); end
        out_axi_rvalid = 0; out_axi_rdata = '0; out_axi_rresp = '0;
      end
    end
  end

  // Ownership monitors: a handshake signal must never reach both requesters or the idle one
  initial forever begin
    @(negedge clk); #2;
    if ((in0_axi_awready && in1_axi_awready) || (in0_axi_wready && in1_axi_wready) ||
        (in0_axi_bvalid && in1_axi_bvalid) || (in0_axi_arready && in1_axi_arready) ||
        (in0_axi_rvalid && in1_axi_rvalid)) excl_viol++;
    if (t1 && (in1_axi_awready || in1_axi_wready || in1_axi_bvalid || in1_axi_arready || in1_axi_rvalid)) mon1++;
    if (t4 && (in0_axi_rvalid || in0_axi_arready || in1_axi_awready || in1_axi_wready || in1_axi_bvalid)) mon4++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    bit ok, h;
    int s0;

    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("rst_awvalid", 32'(out_axi_awvalid), 0);
    check("rst_arvalid", 32'(out_axi_arvalid), 0);
    check("rst_bready", 32'(out_axi_bready), 0);
    check("rst_in0_bvalid", 32'(in0_axi_bvalid), 0);
    check("rst_in1_rvalid", 32'(in1_axi_rvalid), 0);
    check("rst_in0_bresp", 32'(in0_axi_bresp), 0);
    @(negedge clk);

    // Single write from in0, out_awvalid visible the cycle after the grant
    t1 = 1;
    wr_q.delete();
    fork
      do_write(0, 20'h00010, 16'hA5A5);
      begin
        @(negedge clk); #2;
        check("t1_out_awvalid", 32'(out_axi_awvalid), 1);
        check("t1_out_awaddr", 32'(out_axi_awaddr), 32'h10);
        check("t1_out_wdata", 32'(out_axi_wdata), 32'hA5A5);
      end
    join
    t1 = 0;
    check("t1_in1_quiet", mon1, 0);
    check("t1_grant", wr_q.size() > 0 ? wr_q[0] : -1, 0);

    // Contention immediately after reset
    apply_reset();
    wr_q.delete();
    fork
      do_write(0, 20'h00020, 16'($urandom));
      do_write(1, 20'h00021, 16'($urandom));
    join
    rr_model(1, 1, model_last_w);
    check("t2_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) check("t2_order", wr_q[i], exp_q[i]);

    // Repeated contention with random addresses and data
    wr_q.delete();
    wr_cnt[0] = 0; wr_cnt[1] = 0;
    fork
      for (int k = 0; k < 8; k++) begin
        automatic logic [19:0] a = 20'h00100 + 20'(2 * $urandom_range(0, 63));
        a0_q.push_back(a);
        do_write(0, a, 16'($urandom));
      end
      for (int k = 0; k < 8; k++) begin
        automatic logic [19:0] a = 20'h00101 + 20'(2 * $urandom_range(0, 63));
        a1_q.push_back(a);
        do_write(1, a, 16'($urandom));
      end
    join
    rr_model(8, 8, model_last_w);
    check("t3_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) check("t3_order", wr_q[i], exp_q[i]);
    check("t3_b_count0", wr_cnt[0], 8);
    check("t3_b_count1", wr_cnt[1], 8);

    // Concurrent readback on the read path, also contended
    rd_q.delete();
    fork
      for (int k = 0; k < 8; k++) begin
        automatic logic [15:0] rd;
        automatic bit rok;
        do_read(0, a0_q[k], rd, rok);
        if (rok) check("t3_rd0_data", 32'(rd), 32'(ref_mem[int'(a0_q[k])]));
      end
      for (int k = 0; k < 8; k++) begin
        automatic logic [15:0] rd;
        automatic bit rok;
        do_read(1, a1_q[k], rd, rok);
        if (rok) check("t3_rd1_data", 32'(rd), 32'(ref_mem[int'(a1_q[k])]));
      end
    join
    rr_model(8, 8, model_last_r);
    check("t3_rd_count", rd_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++) check("t3_rd_order", rd_q[i], exp_q[i]);

    // Write and read paths outstanding together
    t4 = 1;
    fork
      do_write(0, 20'h00005, 16'h1234);
      begin
        do_read(1, 20'h00005, d, ok);
        if (ok) check("t4_rdata_old_or_new", 32'(d == 16'h0000 || d == 16'h1234), 1);
      end
      begin
        @(negedge clk); #2;
        check("t4_both_valid", 32'(out_axi_awvalid && out_axi_arvalid), 1);
      end
    join
    t4 = 0;
    check("t4_owner_only", mon4, 0);
    model_last_w = 0;
    model_last_r = 1;

    // wvalid held early without awvalid gets no grant
    drive_w(1, 1, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_no_out_w", 32'(out_axi_wvalid || out_axi_awvalid), 0);
      check("t5_no_wready", 32'(in1_axi_wready), 0);
      @(negedge clk);
    end
    s0 = s_wr_cnt;
    do_write(1, 20'h00077, 16'hBEEF);
    check("t5_single_write", s_wr_cnt - s0, 1);
    do_read(0, 20'h00077, d, ok);
    if (ok) check("t5_rdata", 32'(d), 32'hBEEF);

    // Reset while in W_XFER after the address has gone through
    drive_aw(0, 1, 20'h00040); drive_b(0, 1);
    h = 0;
    for (int c = 0; c < 100 && !h; c++) begin #1; h = in0_axi_awready; @(negedge clk); end
    check("t6_aw_accepted", 32'(h), 1);
    drive_aw(0, 0, '0);
    drive_w(0, 1, 16'h5A5A);
    rst = 1;
    #1;
    check("t6_rst_wvalid", 32'(out_axi_wvalid), 0);
    check("t6_rst_wready", 32'(in0_axi_wready), 0);
    check("t6_rst_awvalid", 32'(out_axi_awvalid), 0);
    check("t6_rst_bready", 32'(out_axi_bready), 0);
    @(negedge clk); @(negedge clk);
    drive_w(0, 0, '0); drive_b(0, 0);
    rst = 0;
    model_last_w = 1; model_last_r = 1;
    s0 = s_wr_cnt;
    do_write(0, 20'h00040, 16'h6C6C);
    check("t6_single_write", s_wr_cnt - s0, 1);
    do_read(0, 20'h00040, d, ok);
    if (ok) check("t6_rdata", 32'(d), 32'h6C6C);

    check("exclusive_routing", excl_viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
